// File: rtl/fifo_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rr_sched: round-robin burst scheduler draining N registered-output     |
// | FIFOs into one valid/ready stream. Optional FIFO_RR_SCHED_PRIO_EN adds a     |
// | high-priority mask. Revision: 1.0                                            |
// +----------------------------------------------------------------------------+
module fifo_rr_sched #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         fifo_empty,
    input  logic [N*W-1:0]       fifo_data,
    output logic [N-1:0]         fifo_read,
    input  logic [N-1:0]         prio,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src,
    output logic [N-1:0]         grant
);
    localparam int c_iw = $clog2(N);
    localparam int c_bw = $clog2(MAX_BURST + 1);
    localparam logic [c_bw-1:0] c_max_burst = c_bw'(MAX_BURST);
    localparam logic [c_bw-1:0] c_one       = c_bw'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    logic [N-1:0]      r_grant;
    logic [c_iw-1:0]   r_owner;
    logic [c_iw-1:0]   r_last;
    logic [c_bw-1:0]   r_burst_cnt;
    logic              r_inflight;
    logic [c_iw-1:0]   r_inflight_src;
    logic [1:0]        r_occ;
    logic [W-1:0]      r_buf0_data;
    logic [W-1:0]      r_buf1_data;
    logic [c_iw-1:0]   r_buf0_src;
    logic [c_iw-1:0]   r_buf1_src;

    state_t            w_nxt_state;
    logic [N-1:0]      w_nxt_grant;
    logic [c_iw-1:0]   w_nxt_owner;
    logic [c_iw-1:0]   w_nxt_last;
    logic [c_bw-1:0]   w_nxt_cnt;
    logic              w_rd_en;
    logic [c_iw-1:0]   w_rd_idx;
    logic [c_iw:0]     w_pick;
    logic [N-1:0]      w_owner_bit;
    logic [N-1:0]      w_cand;
    logic              w_cut;
    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_credit;
    logic [W-1:0]      w_new_data;

    // First requester after base, scanning base+1 .. base+N modulo N; MSB = found.
    function automatic logic [c_iw:0] rr_pick(input logic [N-1:0] req, input logic [c_iw-1:0] base);
        logic [c_iw:0]   res;
        logic [c_iw-1:0] idx;
        int              j;
        res = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(base) + k;
            if (j >= N) j = j - N;
            idx = j[c_iw-1:0];
            if (!res[c_iw] && req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef FIFO_RR_SCHED_PRIO_EN
    logic [N-1:0] w_hi;
    always_comb begin
        w_hi   = ~fifo_empty & prio;
        w_cand = (|w_hi) ? w_hi : ~fifo_empty;
        w_cut  = (|w_hi) && !prio[r_owner];
    end
`else
    logic w_unused_prio;
    assign w_unused_prio = ^prio;
    always_comb begin
        w_cand = ~fifo_empty;
        w_cut  = 1'b0;
    end
`endif

    assign w_pop    = out_valid & out_ready;
    assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit = (w_level < 3'd2);

    always_comb begin
        w_new_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_inflight_src == c_iw'(i)) w_new_data = fifo_data[i*W +: W];
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_owner = r_owner;
        w_nxt_last  = r_last;
        w_nxt_cnt   = r_burst_cnt;
        w_rd_en     = 1'b0;
        w_rd_idx    = r_owner;
        w_pick      = '0;
        w_owner_bit = '0;
        w_owner_bit[r_owner] = 1'b1;
        if (r_state == S_IDLE) begin
            w_pick = rr_pick(w_cand, r_last);
            if (w_pick[c_iw] && w_credit) begin
                w_rd_en     = 1'b1;
                w_rd_idx    = w_pick[c_iw-1:0];
                w_nxt_grant = '0;
                w_nxt_grant[w_pick[c_iw-1:0]] = 1'b1;
                w_nxt_owner = w_pick[c_iw-1:0];
                w_nxt_last  = w_pick[c_iw-1:0];
                w_nxt_cnt   = c_one;
                w_nxt_state = S_BURST;
            end
        end else if (!fifo_empty[r_owner] && (r_burst_cnt < c_max_burst) && !w_cut) begin
            if (w_credit) begin
                w_rd_en   = 1'b1;
                w_nxt_cnt = r_burst_cnt + c_one;
            end
        end else begin
            // Rotation happens in the same cycle so back-to-back grants leave no bubble.
            w_pick = rr_pick(w_cand & ~w_owner_bit, r_owner);
            if (w_pick[c_iw]) begin
                w_rd_en     = w_credit;
                w_rd_idx    = w_pick[c_iw-1:0];
                w_nxt_grant = '0;
                w_nxt_grant[w_pick[c_iw-1:0]] = 1'b1;
                w_nxt_owner = w_pick[c_iw-1:0];
                w_nxt_last  = w_pick[c_iw-1:0];
                w_nxt_cnt   = w_credit ? c_one : '0;
            end else if (w_cand[r_owner]) begin
                w_rd_en    = w_credit;
                w_nxt_last = r_owner;
                w_nxt_cnt  = w_credit ? c_one : '0;
            end else begin
                w_nxt_state = S_IDLE;
                w_nxt_grant = '0;
                w_nxt_cnt   = '0;
            end
        end
    end

    always_comb begin
        fifo_read = '0;
        if (w_rd_en && !rst) fifo_read[w_rd_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_owner        <= '0;
            r_last         <= c_iw'(N - 1);
            r_burst_cnt    <= '0;
            r_inflight     <= 1'b0;
            r_inflight_src <= '0;
            r_occ          <= 2'd0;
            r_buf0_data    <= '0;
            r_buf1_data    <= '0;
            r_buf0_src     <= '0;
            r_buf1_src     <= '0;
        end else begin
            r_state        <= w_nxt_state;
            r_grant        <= w_nxt_grant;
            r_owner        <= w_nxt_owner;
            r_last         <= w_nxt_last;
            r_burst_cnt    <= w_nxt_cnt;
            r_inflight     <= w_rd_en;
            r_inflight_src <= w_rd_idx;
            // Entry 0 is the head; the credit rule guarantees no push into a full, unpopped buffer.
            case (r_occ)
                2'd0: begin
                    if (r_inflight) begin
                        r_buf0_data <= w_new_data;
                        r_buf0_src  <= r_inflight_src;
                        r_occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_pop) begin
                        r_buf0_data <= w_new_data;
                        r_buf0_src  <= r_inflight_src;
                    end else if (r_inflight) begin
                        r_buf1_data <= w_new_data;
                        r_buf1_src  <= r_inflight_src;
                        r_occ       <= 2'd2;
                    end else if (w_pop) begin
                        r_occ <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_buf0_data <= r_buf1_data;
                        r_buf0_src  <= r_buf1_src;
                        if (r_inflight) begin
                            r_buf1_data <= w_new_data;
                            r_buf1_src  <= r_inflight_src;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = !rst && (r_occ != 2'd0);
    assign out_data  = rst ? '0 : r_buf0_data;
    assign out_src   = rst ? '0 : r_buf0_src;
    assign grant     = rst ? '0 : r_grant;

endmodule
`default_nettype wire
